// File: rtl/unpool_layer.sv
// 2x2 unpooling: expands a (W/2)x(H/2) source map into a WxH map, one element per cycle.
// MODE 0 divides each source by 4 (avg-pool backward), MODE 1 copies (nearest neighbour).
module unpool_layer #(
  parameter int unsigned FM_WIDTH  = 6,
  parameter int unsigned FM_HEIGHT = 6,
  parameter int unsigned MODE      = 0,
  localparam int unsigned NumOut   = FM_WIDTH * FM_HEIGHT,
  localparam int unsigned NumSrc   = NumOut / 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] input_fm [0:NumSrc-1],
  output logic               busy,
  output logic               out_valid,
  output logic [5:0]         out_index,
  output logic signed [31:0] out_data,
  output logic               done,
  output logic signed [31:0] output_fm [0:NumOut-1]
);

  localparam int unsigned HalfW   = FM_WIDTH / 2;
  localparam int unsigned ColW    = (FM_WIDTH > 1) ? $clog2(FM_WIDTH) : 1;
  localparam int unsigned RowW    = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;
  localparam int unsigned SrcW    = (NumSrc > 1) ? $clog2(NumSrc) : 1;
  localparam logic [5:0]  LastIdx = 6'(NumOut - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(FM_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [RowW-1:0]     row_q, row_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [5:0]          index_q;
  logic signed [31:0]  data_q;
  logic signed [31:0]  src_q [0:NumSrc-1];
  logic signed [31:0]  fm_q [0:NumOut-1];
  logic                load;
  logic                wr_en;
  logic [SrcW-1:0]     src_idx;
  logic signed [31:0]  src;
  logic signed [31:0]  val;

  // Row/column counters track cnt_q so the source address needs no divider.
  always_comb begin
    src_idx = SrcW'(row_q >> 1) * SrcW'(HalfW) + SrcW'(col_q >> 1);
    src     = src_q[src_idx];
    val     = (MODE == 0) ? (src >>> 2) : src;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    done_d  = done_q;
    load    = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        busy_d = 1'b0;
        done_d = (state_q == StDone);
        if (start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = StExpand;
        end
      end
      StExpand: begin
        wr_en   = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (col_q == LastCol) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_q <= '0;
      data_q  <= '0;
      for (int i = 0; i < int'(NumSrc); i++) src_q[i] <= '0;
      for (int i = 0; i < int'(NumOut); i++) fm_q[i] <= '0;
    end else begin
      if (load) begin
        for (int i = 0; i < int'(NumSrc); i++) src_q[i] <= input_fm[i];
      end
      if (wr_en) begin
        index_q      <= cnt_q;
        data_q       <= val;
        fm_q[cnt_q]  <= val;
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_index = index_q;
  assign out_data  = data_q;
  assign done      = done_q;
  assign output_fm = fm_q;

endmodule

// File: tb/tb_unpool_layer.sv
// Directed bench for unpool_layer: one instance per MODE, shared stimulus.
module tb_unpool_layer;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [31:0] input_fm [0:8];
  logic               busy0, valid0, done0, busy1, valid1, done1;
  logic [5:0]         idx0, idx1;
  logic signed [31:0] data0, data1;
  logic signed [31:0] fm0 [0:35];
  logic signed [31:0] fm1 [0:35];
  logic signed [31:0] exp_in [0:8];
  int                 checks = 0;
  int                 failures = 0;
  int                 row0 [0:5] = '{1, 1, 2, 2, 3, 3};
  int                 row5 [0:5] = '{7, 7, 8, 8, 9, 9};

  unpool_layer #(.FM_WIDTH(6), .FM_HEIGHT(6), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .input_fm(input_fm), .busy(busy0),
    .out_valid(valid0), .out_index(idx0), .out_data(data0), .done(done0), .output_fm(fm0)
  );

  unpool_layer #(.FM_WIDTH(6), .FM_HEIGHT(6), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .input_fm(input_fm), .busy(busy1),
    .out_valid(valid1), .out_index(idx1), .out_data(data1), .done(done1), .output_fm(fm1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [31:0] exp_val(input int n, input int mode);
    logic signed [31:0] s;
    s = exp_in[((n / 6) / 2) * 3 + (n % 6) / 2];
    return (mode == 0) ? (s >>> 2) : s;
  endfunction

  function automatic int nonzero0();
    int nz = 0;
    for (int i = 0; i < 36; i++) if (fm0[i] !== 32'sd0) nz++;
    return nz;
  endfunction

  // Full run from an accepted start; inject_at >= 0 pulses start and trashes input mid-run.
  task automatic do_run(input int inject_at);
    input_fm = exp_in;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("k_busy", busy0, 1);
    chk("k_done", done0, 0);
    chk("k_valid", valid0, 0);
    for (int n = 0; n < 36; n++) begin
      tick();
      chk($sformatf("valid_%0d", n), valid0, 1);
      chk($sformatf("index_%0d", n), idx0, n);
      chk($sformatf("data0_%0d", n), data0, exp_val(n, 0));
      chk($sformatf("data1_%0d", n), data1, exp_val(n, 1));
      if (n == inject_at) begin
        start = 1'b1;
        for (int i = 0; i < 9; i++) input_fm[i] = -32'sd1;
      end else begin
        start = 1'b0;
      end
    end
    tick();
    chk("k37_valid", valid0, 0);
    chk("k37_busy", busy0, 0);
    chk("k37_done0", done0, 1);
    chk("k37_done1", done1, 1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 9; i++) input_fm[i] = '0;
    for (int i = 0; i < 9; i++) exp_in[i] = '0;

    #2;
    chk("rst_busy", busy0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_done", done0, 0);
    chk("rst_fm", nonzero0(), 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_busy", busy0, 0);
    chk("idle_done", done0, 0);
    chk("idle_valid", valid0, 0);

    // MODE 0 expansion
    for (int i = 0; i < 9; i++) exp_in[i] = 32'(4 * (i + 1));
    do_run(-1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("row0_%0d", i), fm0[i], row0[i]);
      chk($sformatf("row5_%0d", i), fm0[30 + i], row5[i]);
    end

    // Negative flooring
    for (int i = 0; i < 9; i++) exp_in[i] = '0;
    exp_in[0] = -32'sd5;
    exp_in[4] = 32'sd7;
    do_run(-1);
    chk("neg_0", fm0[0], -2);
    chk("neg_1", fm0[1], -2);
    chk("neg_6", fm0[6], -2);
    chk("neg_7", fm0[7], -2);
    chk("pos_14", fm0[14], 1);
    chk("pos_15", fm0[15], 1);
    chk("pos_20", fm0[20], 1);
    chk("pos_21", fm0[21], 1);
    chk("copy_neg_0", fm1[0], -5);
    chk("copy_pos_21", fm1[21], 7);

    // MODE 1 copy
    for (int i = 0; i < 9; i++) exp_in[i] = 32'(i + 1);
    do_run(-1);
    chk("copy_35", fm1[35], 9);
    chk("copy_3", fm1[3], 2);
    chk("avg_35", fm0[35], 2);
    for (int w = 0; w < 9; w++) begin
      int base;
      base = (w / 3) * 12 + (w % 3) * 2;
      chk($sformatf("win%0d_a", w), fm1[base], w + 1);
      chk($sformatf("win%0d_b", w), fm1[base + 1], w + 1);
      chk($sformatf("win%0d_c", w), fm1[base + 6], w + 1);
      chk($sformatf("win%0d_d", w), fm1[base + 7], w + 1);
    end

    // start pulse and input change mid-run are ignored
    for (int i = 0; i < 9; i++) exp_in[i] = 32'(10 * (i + 1));
    do_run(9);

    // Reset mid-EXPAND, then restart
    for (int i = 0; i < 9; i++) exp_in[i] = 32'(4 * (i + 1));
    input_fm = exp_in;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    chk("pre_rst_index", idx0, 17);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_valid", valid0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_index", idx0, 0);
    chk("mid_rst_data", data0, 0);
    chk("mid_rst_fm", nonzero0(), 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 9; i++) exp_in[i] = -32'(8 * (i + 1));
    do_run(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
